// File: rtl/rc4_pkg.sv
// rc4_pkg: shared constants and FSM state encoding for the RC4 stream engine.
// The DROP state exists only when RC4_DROP_EN is defined.
package rc4_pkg;

   localparam int SBOX_DEPTH  = 256;
   localparam int INIT_CYCLES = 256;
   localparam int KSA_CYCLES  = 512;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_KSA_A,
      ST_KSA_B,
`ifdef RC4_DROP_EN
      ST_DROP,
`endif
      ST_GEN_A,
      ST_GEN_B,
      ST_GEN_C,
      ST_OUT
   } rc4_state_e;

endpackage

// File: rtl/rc4_sbox.sv
// rc4_sbox: 256x8 permutation store with two asynchronous read ports and
// two write ports; on an address collision port B is applied last and wins.
module rc4_sbox
   import rc4_pkg::*;
(
   input  logic       clk,
   input  logic [7:0] i_raddr_a,
   output logic [7:0] o_rdata_a,
   input  logic [7:0] i_raddr_b,
   output logic [7:0] o_rdata_b,
   input  logic       i_we_a,
   input  logic [7:0] i_waddr_a,
   input  logic [7:0] i_wdata_a,
   input  logic       i_we_b,
   input  logic [7:0] i_waddr_b,
   input  logic [7:0] i_wdata_b
);

   logic [7:0] r_mem [SBOX_DEPTH];

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];

   always_ff @(posedge clk) begin
      if (i_we_a) r_mem[i_waddr_a] <= i_wdata_a;
      if (i_we_b) r_mem[i_waddr_b] <= i_wdata_b;
   end

endmodule

// File: rtl/rc4_stream.sv
// rc4_stream: RC4 engine (S-box init, KSA, PRGA) XORing keystream onto a
// valid/ready byte stream. Define RC4_DROP_EN to discard the first DROP_N bytes.
module rc4_stream
   import rc4_pkg::*;
#(
   parameter int KEY_BYTES_MAX = 16,
   parameter int DROP_N        = 256
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [8*KEY_BYTES_MAX-1:0]         key,
   input  logic [$clog2(KEY_BYTES_MAX+1)-1:0] key_len,
   output logic                               busy,
   output logic                               key_err,
   input  logic                               in_valid,
   input  logic [7:0]                         in_data,
   output logic                               in_ready,
   output logic                               out_valid,
   output logic [7:0]                         out_data,
   input  logic                               out_ready
);

   localparam int KL_W   = $clog2(KEY_BYTES_MAX + 1);
   localparam int KIDX_W = (KEY_BYTES_MAX > 1) ? $clog2(KEY_BYTES_MAX) : 1;
   localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);
   localparam logic [7:0] KSA_LAST  = 8'(KSA_CYCLES / 2 - 1);

`ifdef RC4_DROP_EN
   localparam int DROP_W = (DROP_N > 1) ? $clog2(DROP_N) : 1;
   localparam logic [DROP_W-1:0] DROP_LAST = DROP_W'((DROP_N > 0) ? DROP_N - 1 : 0);
   localparam rc4_state_e ST_AFTER_KSA = (DROP_N > 0) ? ST_DROP : ST_GEN_A;

   logic [DROP_W-1:0] r_drop_cnt, w_drop_cnt_next;
   logic              r_dropping, w_dropping_next;
`else
   localparam rc4_state_e ST_AFTER_KSA = ST_GEN_A;

   // DROP_N has no effect without the drop feature
   logic w_unused_drop_n;
   assign w_unused_drop_n = (DROP_N != 0);
`endif

   rc4_state_e                 r_state, w_state_next;
   logic [7:0]                 r_i, w_i_next;
   logic [7:0]                 r_j, w_j_next;
   logic [7:0]                 r_si, w_si_next;
   logic [7:0]                 r_sj, w_sj_next;
   logic [7:0]                 r_data, w_data_next;
   logic [7:0]                 r_out_data, w_out_data_next;
   logic [KIDX_W-1:0]          r_kidx, w_kidx_next;
   logic [8*KEY_BYTES_MAX-1:0] r_key, w_key_next;
   logic [KL_W-1:0]            r_key_len, w_key_len_next;
   logic                       r_key_err, w_key_err_next;

   logic [7:0]      w_raddr_a, w_rdata_a, w_rdata_b;
   logic            w_we_a, w_we_b;
   logic [7:0]      w_waddr_a, w_wdata_a, w_waddr_b, w_wdata_b;
   logic [7:0]      w_i_inc;
   logic [KL_W-1:0] w_kidx_ext;
   logic            w_key_len_ok;
   logic [7:0]      w_key_arr [KEY_BYTES_MAX];

   for (genvar gi = 0; gi < KEY_BYTES_MAX; gi++) begin : g_key_bytes
      assign w_key_arr[gi] = r_key[8*gi +: 8];
   end

   assign w_i_inc      = r_i + 8'd1;
   assign w_kidx_ext   = KL_W'(r_kidx) + KL_W'(1);
   assign w_key_len_ok = (key_len != '0) && (32'(key_len) <= 32'(KEY_BYTES_MAX));

   rc4_sbox u_sbox (
      .clk       (clk),
      .i_raddr_a (w_raddr_a),
      .o_rdata_a (w_rdata_a),
      .i_raddr_b (r_j),
      .o_rdata_b (w_rdata_b),
      .i_we_a    (w_we_a),
      .i_waddr_a (w_waddr_a),
      .i_wdata_a (w_wdata_a),
      .i_we_b    (w_we_b),
      .i_waddr_b (w_waddr_b),
      .i_wdata_b (w_wdata_b)
   );

   always_comb begin
      w_state_next    = r_state;
      w_i_next        = r_i;
      w_j_next        = r_j;
      w_si_next       = r_si;
      w_sj_next       = r_sj;
      w_data_next     = r_data;
      w_out_data_next = r_out_data;
      w_kidx_next     = r_kidx;
      w_key_next      = r_key;
      w_key_len_next  = r_key_len;
      w_key_err_next  = r_key_err;
      w_raddr_a       = r_i;
      w_we_a          = 1'b0;
      w_waddr_a       = r_i;
      w_wdata_a       = r_i;
      w_we_b          = 1'b0;
      w_waddr_b       = r_j;
      w_wdata_b       = r_si;
`ifdef RC4_DROP_EN
      w_drop_cnt_next = r_drop_cnt;
      w_dropping_next = r_dropping;
`endif

      case (r_state)
         ST_INIT: begin
            w_we_a   = 1'b1;
            w_i_next = w_i_inc;
            if (r_i == INIT_LAST) begin
               w_i_next     = '0;
               w_j_next     = '0;
               w_kidx_next  = '0;
               w_state_next = ST_KSA_A;
            end
         end
         ST_KSA_A: begin
            w_si_next    = w_rdata_a;
            w_j_next     = r_j + w_rdata_a + w_key_arr[r_kidx];
            w_kidx_next  = (w_kidx_ext == r_key_len) ? '0 : r_kidx + KIDX_W'(1);
            w_state_next = ST_KSA_B;
         end
         ST_KSA_B: begin
            // Swap S[i] and S[j]; with i==j both ports write the same value
            w_sj_next    = w_rdata_b;
            w_we_a       = 1'b1;
            w_wdata_a    = w_rdata_b;
            w_we_b       = 1'b1;
            w_i_next     = w_i_inc;
            w_state_next = ST_KSA_A;
            if (r_i == KSA_LAST) begin
               w_i_next     = '0;
               w_j_next     = '0;
               w_state_next = ST_AFTER_KSA;
`ifdef RC4_DROP_EN
               w_drop_cnt_next = '0;
               w_dropping_next = (DROP_N > 0);
`endif
            end
         end
`ifdef RC4_DROP_EN
         ST_DROP: begin
            w_raddr_a    = w_i_inc;
            w_i_next     = w_i_inc;
            w_si_next    = w_rdata_a;
            w_j_next     = r_j + w_rdata_a;
            w_state_next = ST_GEN_B;
         end
`endif
         ST_GEN_A: begin
            w_raddr_a = w_i_inc;
            if (in_valid) begin
               w_data_next  = in_data;
               w_i_next     = w_i_inc;
               w_si_next    = w_rdata_a;
               w_j_next     = r_j + w_rdata_a;
               w_state_next = ST_GEN_B;
            end
         end
         ST_GEN_B: begin
            w_sj_next    = w_rdata_b;
            w_we_a       = 1'b1;
            w_wdata_a    = w_rdata_b;
            w_we_b       = 1'b1;
            w_state_next = ST_GEN_C;
         end
         ST_GEN_C: begin
            w_raddr_a    = r_si + r_sj;
            w_out_data_next = r_data ^ w_rdata_a;
            w_state_next = ST_OUT;
`ifdef RC4_DROP_EN
            if (r_dropping) begin
               w_out_data_next = r_out_data;
               w_drop_cnt_next = r_drop_cnt + DROP_W'(1);
               w_state_next    = ST_DROP;
               if (r_drop_cnt == DROP_LAST) begin
                  w_dropping_next = 1'b0;
                  w_state_next    = ST_GEN_A;
               end
            end
`endif
         end
         ST_OUT: begin
            if (out_ready) w_state_next = ST_GEN_A;
         end
         default: ;
      endcase

      // A start from any state restarts setup or, if illegal, parks in IDLE
      if (start) begin
`ifdef RC4_DROP_EN
         w_dropping_next = 1'b0;
`endif
         if (w_key_len_ok) begin
            w_state_next   = ST_INIT;
            w_i_next       = '0;
            w_j_next       = '0;
            w_kidx_next    = '0;
            w_key_next     = key;
            w_key_len_next = key_len;
            w_key_err_next = 1'b0;
         end else begin
            w_state_next   = ST_IDLE;
            w_key_err_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_i        <= '0;
         r_j        <= '0;
         r_si       <= '0;
         r_sj       <= '0;
         r_data     <= '0;
         r_out_data <= '0;
         r_kidx     <= '0;
         r_key      <= '0;
         r_key_len  <= '0;
         r_key_err  <= 1'b0;
`ifdef RC4_DROP_EN
         r_drop_cnt <= '0;
         r_dropping <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_next;
         r_i        <= w_i_next;
         r_j        <= w_j_next;
         r_si       <= w_si_next;
         r_sj       <= w_sj_next;
         r_data     <= w_data_next;
         r_out_data <= w_out_data_next;
         r_kidx     <= w_kidx_next;
         r_key      <= w_key_next;
         r_key_len  <= w_key_len_next;
         r_key_err  <= w_key_err_next;
`ifdef RC4_DROP_EN
         r_drop_cnt <= w_drop_cnt_next;
         r_dropping <= w_dropping_next;
`endif
      end
   end

`ifdef RC4_DROP_EN
   assign busy = (r_state == ST_INIT) || (r_state == ST_KSA_A) || (r_state == ST_KSA_B) ||
                 (r_state == ST_DROP) || r_dropping;
`else
   assign busy = (r_state == ST_INIT) || (r_state == ST_KSA_A) || (r_state == ST_KSA_B);
`endif
   assign in_ready  = (r_state == ST_GEN_A);
   assign out_valid = (r_state == ST_OUT);
   assign out_data  = r_out_data;
   assign key_err   = r_key_err;

endmodule

// File: tb/tb_rc4_stream.sv
// tb_rc4_stream: directed RC4 vectors, backpressure, illegal key lengths,
// reset and abort checks for rc4_stream.
module tb_rc4_stream;

   localparam int KBM  = 16;
   localparam int KLW  = $clog2(KBM + 1);
   localparam int DROP = 256;
`ifdef RC4_DROP_EN
   localparam int SETUP_LAT = 768 + 3 * DROP;
`else
   localparam int SETUP_LAT = 768;
`endif

   logic             clk      = 1'b0;
   logic             rst_n    = 1'b1;
   logic             start    = 1'b0;
   logic [8*KBM-1:0] key      = '0;
   logic [KLW-1:0]   key_len  = '0;
   logic             in_valid = 1'b0;
   logic [7:0]       in_data  = '0;
   logic             out_ready = 1'b1;
   logic             busy, key_err, in_ready, out_valid;
   logic [7:0]       out_data;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   rc4_stream #(.KEY_BYTES_MAX(KBM), .DROP_N(DROP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key       (key),
      .key_len   (key_len),
      .busy      (busy),
      .key_err   (key_err),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

`ifdef RC4_DROP_EN
   // Software RC4-drop[DROP] reference; replaces the plain vectors in this build
   task automatic ref_model(input string k, input string pt);
      int s[256];
      int i, j, t, ks;
      logic [7:0] kb, pb;
      for (int n = 0; n < 256; n++) s[n] = n;
      j = 0;
      for (int n = 0; n < 256; n++) begin
         kb = k[n % k.len()];
         j = (j + s[n] + int'(kb)) % 256;
         t = s[n]; s[n] = s[j]; s[j] = t;
      end
      i = 0; j = 0;
      exp_q.delete();
      for (int n = 0; n < DROP + pt.len(); n++) begin
         i = (i + 1) % 256;
         j = (j + s[i]) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         ks = s[(s[i] + s[j]) % 256];
         if (n >= DROP) begin
            pb = pt[n - DROP];
            exp_q.push_back(pb ^ 8'(ks));
         end
      end
   endtask
`endif

   task automatic do_start(input string k, input int klen);
      key = '0;
      for (int n = 0; n < k.len() && n < KBM; n++) key[8*n +: 8] = k[n];
      key_len = KLW'(klen);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_setup(input string tag);
      int cyc = 0;
      check({tag, "_busy_rise"}, busy, 1);
      while (busy && cyc < SETUP_LAT + 100) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_setup_lat"}, cyc, SETUP_LAT);
      check({tag, "_ready_after_setup"}, in_ready, 1);
   endtask

   task automatic send_byte(input string tag, input int idx, input logic [7:0] d, input int stall);
      int w = 0;
      logic [7:0] held;
      logic stable;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      if (stall > 0) out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      w = 1;
      while (!out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_byte_lat"}, w, 3);
      if (stall > 0) begin
         held   = out_data;
         stable = 1'b1;
         repeat (stall) begin
            @(negedge clk);
            if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
         end
         check({tag, "_stall_hold"}, stable, 1);
         out_ready = 1'b1;
      end
      $display("[TB] %s byte %0d in=%02h out=%02h", tag, idx, d, out_data);
      check($sformatf("%s_b%0d", tag, idx), out_data, exp_q[idx]);
      @(negedge clk);
   endtask

   task automatic run_vec(input string tag, input string k, input string pt, input int stall_idx);
      do_start(k, k.len());
      check({tag, "_key_err"}, key_err, 0);
      wait_setup(tag);
      for (int n = 0; n < pt.len(); n++)
         send_byte(tag, n, pt[n], (n == stall_idx) ? 10 : 0);
   endtask

   task automatic load_key_vec();
      exp_q = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
`ifdef RC4_DROP_EN
      ref_model("Key", "Plaintext");
`endif
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_key_err", key_err, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      load_key_vec();
      run_vec("key", "Key", "Plaintext", -1);

      exp_q = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
`ifdef RC4_DROP_EN
      ref_model("Wiki", "pedia");
`endif
      run_vec("wiki", "Wiki", "pedia", -1);

      exp_q = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B, 8'h38,
                8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};
`ifdef RC4_DROP_EN
      ref_model("Secret", "Attack at dawn");
`endif
      run_vec("secret", "Secret", "Attack at dawn", -1);

      load_key_vec();
      run_vec("stall", "Key", "Plaintext", 1);

      // Illegal key lengths: flag sets, engine stays idle
      do_start("Key", 0);
      check("len0_key_err", key_err, 1);
      check("len0_busy", busy, 0);
      repeat (3) @(negedge clk);
      check("len0_idle", busy | in_ready | out_valid, 0);
      do_start("Key", KBM + 1);
      check("lenmax1_key_err", key_err, 1);
      check("lenmax1_busy", busy, 0);

      exp_q = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
`ifdef RC4_DROP_EN
      ref_model("Wiki", "pedia");
`endif
      run_vec("clear", "Wiki", "pedia", -1);

      // Asynchronous reset in the middle of KSA
      do_start("Key", 3);
      repeat (400) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midksa_busy", busy, 0);
      check("midksa_in_ready", in_ready, 0);
      check("midksa_out_valid", out_valid, 0);
      check("midksa_out_data", out_data, 0);
      check("midksa_key_err", key_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Restart while a byte sits in GEN_B
      load_key_vec();
      do_start("Key", 3);
      wait_setup("abort_pre");
      in_valid = 1'b1;
      in_data  = 8'h50;
      @(negedge clk);
      in_valid = 1'b0;
      check("abort_in_genb", in_ready, 0);
      do_start("Key", 3);
      wait_setup("abort");
      for (int n = 0; n < 9; n++) begin
         string pt;
         pt = "Plaintext";
         send_byte("abort", n, pt[n], 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
